// File: rtl/graphix_pkg.sv
// Shared definitions for the CCU command path.
// - Opcode and NOP byte values, parameter-byte counts per opcode.
// - Emitter state enum used by cmd_framer.
// - param_count(): number of parameter bytes for an opcode, 0 when unknown.
package graphix_pkg;

  localparam logic [7:0] OP_POINT = 8'h50;
  localparam logic [7:0] OP_LINE  = 8'h4C;
  localparam logic [7:0] CMD_NOP  = 8'h00;

  localparam int unsigned P_PARAMS = 3;
  localparam int unsigned L_PARAMS = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_OPC    = 3'd1,
    ST_PARAM  = 3'd2,
    ST_STALL  = 3'd3,
    ST_REPLAY = 3'd4,
    ST_GAP    = 3'd5
  } emit_state_e;

  function automatic logic [2:0] param_count(input logic [7:0] op);
    case (op)
      OP_POINT: param_count = 3'(P_PARAMS);
      OP_LINE:  param_count = 3'(L_PARAMS);
      default:  param_count = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Byte FIFO, DEPTH x 8, first-word-fall-through read port.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset (pointers only)
//   push, push_data     write strobe and byte; ignored when full
//   pop                 read strobe; ignored when empty
//   pop_data            byte at the head (valid while !empty)
//   full, empty, count  occupancy status
// Pointers carry one extra wrap bit so full and empty stay distinct
// after the address bits wrap.
module cmd_fifo #(
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    pop_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        push_ok, pop_ok;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign count = wr_ptr_q - rd_ptr_q;

  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: nothing is read until it has been written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/cmd_framer.sv
// Upstream command stage for CCU.
// Accepts host bytes, parses them into 'P' / 'L' frames, buffers them in a
// byte FIFO and replays each complete frame to CCU one byte per clock, adding
// the compute stall and X/Y replay that 'L' needs plus a NOP gap after every
// command. Unknown opcodes are swallowed and flagged.
// Ports:
//   clk, rst_n     clock shared with CCU, asynchronous active-low reset
//   in_data        host byte
//   in_valid       host byte valid
//   in_ready       framer can take a byte
//   cmd            byte stream to CCU, 8'h00 = NOP
//   cmd_active     cmd carries a framed byte or an in-frame stall
//   err_opcode     one-cycle pulse: an unknown opcode was discarded
//   busy           FIFO non-empty or emitter not idle
// Handshake: a byte transfers on a rising edge where in_valid and in_ready
// are both high; the host holds in_data stable while in_valid is high and
// in_ready is low. in_ready depends only on framer state, never on in_valid.
module cmd_framer
  import graphix_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int GAP    = 2,
  parameter int LSTALL = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] cmd,
  output logic       cmd_active,
  output logic       err_opcode,
  output logic       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT    = (AW+1)'(DEPTH);
  localparam logic [7:0]  STALL_LAST  = 8'(LSTALL - 1);
  localparam logic [7:0]  GAP_LAST    = 8'(GAP - 1);
  localparam logic [7:0]  P_LAST      = 8'(P_PARAMS - 1);
  localparam logic [7:0]  L_LAST      = 8'(L_PARAMS - 1);

  // FIFO interface
  logic          push, pop;
  logic [7:0]    fifo_rdata;
  logic          fifo_full, fifo_empty;
  logic [AW:0]   fifo_count;
  logic [AW:0]   count_next;

  // Ingress parser
  logic          xfer;
  logic [2:0]    op_params;
  logic [2:0]    rem_q, rem_d;
  logic          complete;
  logic          err_opcode_q, err_opcode_d;

  // Frame accounting
  logic [AW:0]   frames_ready_q, frames_ready_d;
  logic          frame_taken;

  // Emitter
  emit_state_e   state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          is_line_q, is_line_d;
  logic [7:0]    xs_q, xs_d;
  logic [7:0]    ys_q, ys_d;
  logic [7:0]    last_param;

  // Registered outputs
  logic [7:0]    cmd_q, cmd_d;
  logic          cmd_active_q, cmd_active_d;
  logic          in_ready_q, in_ready_d;
  logic          busy_q, busy_d;

  cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign xfer      = in_valid & in_ready_q;
  assign op_params = param_count(in_data);

  // ---------------------------------------------------------------- parser
  // rem_q == 0 means the next byte is an opcode; only then is it checked.
  always_comb begin
    push         = 1'b0;
    complete     = 1'b0;
    rem_d        = rem_q;
    err_opcode_d = 1'b0;
    if (xfer) begin
      if (rem_q == 3'd0) begin
        if (op_params != 3'd0) begin
          push  = 1'b1;
          rem_d = op_params;
        end else begin
          err_opcode_d = 1'b1;
        end
      end else begin
        push  = 1'b1;
        rem_d = rem_q - 3'd1;
        if (rem_q == 3'd1) complete = 1'b1;
      end
    end
  end

  // A completion and an opcode pop in the same cycle cancel out.
  always_comb begin
    frames_ready_d = frames_ready_q;
    case ({complete, frame_taken})
      2'b10:   frames_ready_d = frames_ready_q + 1'b1;
      2'b01:   frames_ready_d = frames_ready_q - 1'b1;
      default: frames_ready_d = frames_ready_q;
    endcase
  end

  // ------------------------------------------------------ emitter: state reg
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      is_line_q <= 1'b0;
      xs_q      <= '0;
      ys_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_line_q <= is_line_d;
      xs_q      <= xs_d;
      ys_q      <= ys_d;
    end
  end

  // --------------------------------------------------- emitter: next state
  // cnt_q counts cycles spent in the current state from zero.
  assign last_param = is_line_q ? L_LAST : P_LAST;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_line_d = is_line_q;
    xs_d      = xs_q;
    ys_d      = ys_q;
    case (state_q)
      ST_IDLE: begin
        if (frames_ready_q != '0) state_d = ST_OPC;
      end
      ST_OPC: begin
        is_line_d = (fifo_rdata == OP_LINE);
        cnt_d     = '0;
        state_d   = ST_PARAM;
      end
      ST_PARAM: begin
        if (is_line_q && cnt_q == 8'd0) xs_d = fifo_rdata;
        if (is_line_q && cnt_q == 8'd1) ys_d = fifo_rdata;
        if (cnt_q == last_param) begin
          cnt_d   = '0;
          state_d = is_line_q ? ST_STALL : ST_GAP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_STALL: begin
        if (cnt_q == STALL_LAST) begin
          cnt_d   = '0;
          state_d = ST_REPLAY;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_REPLAY: begin
        if (cnt_q == 8'd1) begin
          cnt_d   = '0;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_GAP: begin
        // Jump straight to the next opcode when one is waiting, so the
        // inter-command spacing is exactly GAP NOPs.
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = (frames_ready_q != '0) ? ST_OPC : ST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ------------------------------------------------------- emitter: outputs
  // cmd is registered, so it shows what the state drove one cycle earlier.
  always_comb begin
    pop          = 1'b0;
    frame_taken  = 1'b0;
    cmd_d        = CMD_NOP;
    cmd_active_d = 1'b0;
    case (state_q)
      ST_OPC: begin
        pop          = 1'b1;
        frame_taken  = 1'b1;
        cmd_d        = fifo_rdata;
        cmd_active_d = 1'b1;
      end
      ST_PARAM: begin
        pop          = 1'b1;
        cmd_d        = fifo_rdata;
        cmd_active_d = 1'b1;
      end
      ST_STALL: begin
        cmd_active_d = 1'b1;
      end
      ST_REPLAY: begin
        cmd_d        = (cnt_q == 8'd0) ? xs_q : ys_q;
        cmd_active_d = 1'b1;
      end
      default: begin
        cmd_d        = CMD_NOP;
        cmd_active_d = 1'b0;
      end
    endcase
  end

  // Occupancy after this edge, so in_ready never admits a push at full.
  assign count_next = fifo_count + (AW+1)'(push & ~fifo_full)
                                 - (AW+1)'(pop & ~fifo_empty);

  always_comb begin
    in_ready_d = (count_next != FULL_CNT);
    busy_d     = (count_next != '0) || (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q          <= '0;
      err_opcode_q   <= 1'b0;
      frames_ready_q <= '0;
      cmd_q          <= CMD_NOP;
      cmd_active_q   <= 1'b0;
      in_ready_q     <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      rem_q          <= rem_d;
      err_opcode_q   <= err_opcode_d;
      frames_ready_q <= frames_ready_d;
      cmd_q          <= cmd_d;
      cmd_active_q   <= cmd_active_d;
      in_ready_q     <= in_ready_d;
      busy_q         <= busy_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign cmd        = cmd_q;
  assign cmd_active = cmd_active_q;
  assign err_opcode = err_opcode_q;
  assign busy       = busy_q;

endmodule
